alu_control_sequencer: RTL
==========================

# alu_control_sequencer

Parametrised hardwired control unit for the bus datapath. It generates the fetch and execute control strobes that benches previously drove by hand: T0–T2 fetch, then register-register ALU, MUL/DIV, NOP and HALT execute sequences. It adds a memory-ready handshake, run/stop control, illegal-opcode detection and an instruction counter. The block sits beside `datapath`: its strobes drive the datapath, and it reads the datapath IR contents.

## Interface
- `NUM_REGS`, 16: general registers; `RW = $clog2(NUM_REGS)` is the register-field width.
- `OP_WIDTH`, 5: opcode width and `operation` width.
- `INSTR_WIDTH`, 32: IR width.
- `CNT_WIDTH`, 16: instruction counter width.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  begin fetching; honoured only in IDLE.
- `stop`  in  1  request halt at the next instruction boundary; sticky until honoured.
- `mem_ready`  in  1  memory read data valid this cycle.
- `IR`  in  INSTR_WIDTH  current instruction. Fields: opcode `[IW-1 -: OW]`, Ra `[IW-OW-1 -: RW]`, Rb next `RW` bits, Rc next `RW` bits.
- `PCout`, `PCin`, `IncPC`, `MARin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `ZHighout`, `LOin`, `HIin`  out  1 each  datapath strobes.
- `reg_in`, `reg_out`  out  NUM_REGS  one-hot register enables.
- `operation`  out  OP_WIDTH  ALU op code.
- `run`  out  1  high whenever the state is not IDLE.
- `illegal`  out  1  one-cycle pulse on an unrecognised opcode.
- `step`  out  4  encoded current state.
- `icount`  out  CNT_WIDTH  number of completed instructions.

## Operation
- Moore FSM. All strobes decode from the registered state only. Strobes not listed for a state are 0.
- IDLE (step 0): all strobes 0. Goes to T0 when `start`=1 and `stop`=0.
- T0 (1): `PCout`, `MARin`, `IncPC`, `Zin`.
- T1 (2): `Zlowout`, `PCin`.
- T1W (3): `Read`, `MDRin`. Stays in T1W while `mem_ready`=0 and exits when it is 1. There is no timeout.
- T2 (4): `MDRout`, `IRin`.
- T3 (5): branches on opcode.
  - ALU ops 00011–01110: `reg_out[Rb]`, `Yin`.
  - MUL 01111 / DIV 10000: `reg_out[Ra]`, `Yin`.
  - NOP 11010: no strobes; instruction completes here.
  - HALT 11011: no strobes; instruction completes here.
  - Any other opcode: `illegal`=1; treated as NOP.
- T4 (6): `reg_out[Rc]` for ALU ops, `reg_out[Rb]` for MUL/DIV; plus `Zin` and `operation`=opcode. `operation`=0 in all other states.
- T5 (7): ALU ops assert `Zlowout`, `reg_in[Ra]` and complete. MUL/DIV assert `Zlowout`, `LOin`.
- T6 (8): MUL/DIV only: `ZHighout`, `HIin`; instruction completes.
- Completion (boundary):
  - `icount` increments; it wraps to 0 at all-ones.
  - Next state is IDLE if the instruction was HALT or the `stop` latch is set; otherwise T0.
  - The `stop` latch clears on entering IDLE.
- `stop` pulses in any non-IDLE state are latched. The current instruction always finishes.
- `start` outside IDLE is ignored. `start` and `stop` in the same IDLE cycle: remain in IDLE.
- `IR` must be stable from T3 through completion; the block does not capture it.

## Timing
- Reset: on a clock edge with `clear`=1:
  - state becomes IDLE;
  - every output is 0, including `icount`;
  - the `stop` latch clears.
  
  This holds when `clear` arrives mid-instruction or mid-wait.
- With `mem_ready` high at first T1W cycle, instruction lengths are:
  - ALU ops: 7 cycles (T0..T5);
  - MUL/DIV: 8 cycles;
  - NOP, HALT and illegal opcodes: 5 cycles.
  
  Each extra wait cycle in T1W adds 1.
- `reg_in`/`reg_out` are exactly one-hot when active, otherwise all zero. Register indices need no range check (`NUM_REGS` is a power of two).
- `illegal` is high for exactly one cycle, in T3.

## Test plan
- Reset, `start`, `IR`=0x1A1B8000 (ADD, Ra=4, Rb=3, Rc=7), `mem_ready` tied 1:
  - T3: `reg_out`=0x0008, `Yin`;
  - T4: `reg_out`=0x0080, `operation`=00011, `Zin`;
  - T5: `reg_in`=0x0010, `Zlowout`;
  - then T0 again; `icount`=1 after 7 cycles.
- `mem_ready` held low 3 cycles in T1W: `Read`/`MDRin` are high for 4 cycles and `IRin` is delayed 3 cycles. A MUL (`IR`=0x7A180000) then runs T5 `LOin`, T6 `HIin` with `reg_out`=0x0010 at T3.
- `IR`=0xD8000000 (HALT): after T3 the state is IDLE, `run`=0, `icount`=1. `start` restarts at T0.
- `stop` pulsed during T4 of an ADD: `reg_in`[Ra] still asserts in T5, then IDLE. Separately, `start`+`stop` together in IDLE: the block stays in IDLE.
- Opcode 10101: one-cycle `illegal` pulse in T3, no `reg_in`, next state T0, `icount` increments.
- `clear` asserted in T4: all outputs 0 next cycle, `icount`=0, state IDLE. Separately, from `icount`=0xFFFF one NOP completes: `icount` wraps to 0.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired control unit for the bus datapath.
// Steps through fetch (T0..T2, with a memory-ready wait in T1W) and the
// execute sequences for ALU, MUL/DIV, NOP and HALT. It also handles
// run/stop, flags illegal opcodes and counts completed instructions.
module alu_control_sequencer #(
   parameter int NUM_REGS    = 16,
   parameter int OP_WIDTH    = 5,
   parameter int INSTR_WIDTH = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   Clock,
   input  logic                   clear,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   mem_ready,
   input  logic [INSTR_WIDTH-1:0] IR,
   output logic                   PCout,
   output logic                   PCin,
   output logic                   IncPC,
   output logic                   MARin,
   output logic                   Read,
   output logic                   MDRin,
   output logic                   MDRout,
   output logic                   IRin,
   output logic                   Yin,
   output logic                   Zin,
   output logic                   Zlowout,
   output logic                   ZHighout,
   output logic                   LOin,
   output logic                   HIin,
   output logic [NUM_REGS-1:0]    reg_in,
   output logic [NUM_REGS-1:0]    reg_out,
   output logic [OP_WIDTH-1:0]    operation,
   output logic                   run,
   output logic                   illegal,
   output logic [3:0]             step,
   output logic [CNT_WIDTH-1:0]   icount
);

   localparam int RW = $clog2(NUM_REGS);
   localparam int IW = INSTR_WIDTH;
   localparam int OW = OP_WIDTH;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T1W  = 4'd3,
      T2   = 4'd4,
      T3   = 4'd5,
      T4   = 4'd6,
      T5   = 4'd7,
      T6   = 4'd8
   } state_t;

   state_t                 state_q, state_d;
   logic                   stopLatch_q, stopLatch_d;
   logic [CNT_WIDTH-1:0]   icount_q, icount_d;

   logic [OW-1:0]          opcode;
   logic [RW-1:0]          ra, rb, rc;
   logic                   isAlu, isMulDiv, isNop, isHalt;
   logic                   complete;
   logic [NUM_REGS-1:0]    oneHotBase;
   logic                   unusedIrBits;

   assign opcode = IR[IW-1 -: OW];
   assign ra     = IR[IW-OW-1 -: RW];
   assign rb     = IR[IW-OW-RW-1 -: RW];
   assign rc     = IR[IW-OW-2*RW-1 -: RW];
   assign unusedIrBits = ^IR[IW-OW-3*RW-1:0];

   assign isAlu    = (opcode >= OW'(3)) && (opcode <= OW'(14));
   assign isMulDiv = (opcode == OW'(15)) || (opcode == OW'(16));
   assign isNop    = (opcode == OW'(26));
   assign isHalt   = (opcode == OW'(27));

   assign oneHotBase = {{(NUM_REGS-1){1'b0}}, 1'b1};

   // Next state, stop latch and instruction counter; completion decides
   // between fetching again and returning to IDLE.
   always_comb begin
      state_d     = state_q;
      stopLatch_d = stopLatch_q;
      icount_d    = icount_q;
      complete    = 1'b0;
      if (state_q != IDLE && stop) begin
         stopLatch_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            stopLatch_d = 1'b0;
            if (start && !stop) begin
               state_d = T0;
            end
         end
         T0:  state_d = T1;
         T1:  state_d = T1W;
         T1W: begin
            if (mem_ready) begin
               state_d = T2;
            end
         end
         T2:  state_d = T3;
         T3: begin
            if (isAlu || isMulDiv) begin
               state_d = T4;
            end else begin
               complete = 1'b1;
            end
         end
         T4:  state_d = T5;
         T5: begin
            if (isAlu) begin
               complete = 1'b1;
            end else begin
               state_d = T6;
            end
         end
         T6:  complete = 1'b1;
         default: state_d = IDLE;
      endcase
      if (complete) begin
         icount_d = icount_q + 1'b1;
         if ((state_q == T3 && isHalt) || stopLatch_q || stop) begin
            state_d     = IDLE;
            stopLatch_d = 1'b0;
         end else begin
            state_d = T0;
         end
      end
   end

   // State register with synchronous clear.
   always_ff @(posedge Clock) begin
      if (clear) begin
         state_q     <= IDLE;
         stopLatch_q <= 1'b0;
         icount_q    <= '0;
      end else begin
         state_q     <= state_d;
         stopLatch_q <= stopLatch_d;
         icount_q    <= icount_d;
      end
   end

   // Moore strobe decode from the registered state; register selects come
   // from the IR fields, which the datapath holds stable from T3 onward.
   always_comb begin
      PCout     = 1'b0;
      PCin      = 1'b0;
      IncPC     = 1'b0;
      MARin     = 1'b0;
      Read      = 1'b0;
      MDRin     = 1'b0;
      MDRout    = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      Zin       = 1'b0;
      Zlowout   = 1'b0;
      ZHighout  = 1'b0;
      LOin      = 1'b0;
      HIin      = 1'b0;
      reg_in    = '0;
      reg_out   = '0;
      operation = '0;
      illegal   = 1'b0;
      case (state_q)
         T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
         end
         T1W: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         T3: begin
            if (isAlu) begin
               reg_out = oneHotBase << rb;
               Yin     = 1'b1;
            end else if (isMulDiv) begin
               reg_out = oneHotBase << ra;
               Yin     = 1'b1;
            end else if (!isNop && !isHalt) begin
               illegal = 1'b1;
            end
         end
         T4: begin
            reg_out   = isAlu ? (oneHotBase << rc) : (oneHotBase << rb);
            Zin       = 1'b1;
            operation = opcode;
         end
         T5: begin
            Zlowout = 1'b1;
            if (isAlu) begin
               reg_in = oneHotBase << ra;
            end else begin
               LOin = 1'b1;
            end
         end
         T6: begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
         end
         default: ;
      endcase
   end

   assign run    = (state_q != IDLE);
   assign step   = state_q;
   assign icount = icount_q;

endmodule
